// File: rtl/mips_mem_if.sv
`default_nettype none
// ============================================================================
//  Module   : mips_mem_if
//  Purpose  : Variable-latency req/ack SRAM bus interface that stalls the
//             multicycle MIPS controller for the duration of each access.
//             Optional macro MEM_TIMEOUT_EN adds an abort after TIMEOUT cycles.
//  Revision : 1.0 - initial release
// ============================================================================
module mips_mem_if #(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int TIMEOUT = 255
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          cpu_rd,
  input  logic          cpu_wr,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic [DW-1:0] cpu_rdata,
  output logic          cpu_stall,
  output logic          cpu_err,
  output logic          mem_req,
  output logic          mem_we,
  output logic [AW-3:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic          mem_ack,
  input  logic [DW-1:0] mem_rdata
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [DW-1:0] c_ABORT_DATA = DW'(32'hDEADBEEF);

  state_t r_state;
  state_t w_next;
  logic   w_timeout;
  logic   w_start;
  logic   w_unused;

  // Byte-lane bits are dropped; TIMEOUT is only consumed by the timeout build.
  assign w_unused = ^{cpu_addr[1:0], 16'(TIMEOUT)};
  assign w_start  = cpu_rd | cpu_wr;

`ifdef MEM_TIMEOUT_EN
  logic [15:0] r_tmo_cnt;

  assign w_timeout = (r_state == S_REQ) && !mem_ack && (r_tmo_cnt == 16'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_tmo_cnt <= '0;
      cpu_err   <= 1'b0;
    end else begin
      cpu_err <= w_timeout;
      if (r_state == S_REQ)
        r_tmo_cnt <= r_tmo_cnt + 16'd1;
      else
        r_tmo_cnt <= '0;
    end
  end
`else
  assign w_timeout = 1'b0;
  assign cpu_err   = 1'b0;
`endif

  always_comb begin
    w_next    = r_state;
    cpu_stall = 1'b0;
    mem_req   = 1'b0;
    case (r_state)
      S_IDLE: begin
        cpu_stall = w_start;
        if (w_start) w_next = S_REQ;
      end
      S_REQ: begin
        mem_req   = 1'b1;
        cpu_stall = 1'b1;
        if (mem_ack || w_timeout) w_next = S_DONE;
      end
      S_DONE: w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= S_IDLE;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      cpu_rdata <= '0;
    end else begin
      r_state <= w_next;
      // Write wins when both requests are raised together.
      if (r_state == S_IDLE && w_start) begin
        mem_we    <= cpu_wr;
        mem_addr  <= cpu_addr[AW-1:2];
        mem_wdata <= cpu_wdata;
      end
      if (r_state == S_REQ && !mem_we) begin
        if (mem_ack)
          cpu_rdata <= mem_rdata;
        else if (w_timeout)
          cpu_rdata <= c_ABORT_DATA;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mips_mem_if.sv
`default_nettype none
// Testbench for mips_mem_if: scoreboard of expected bus transactions and read
// data, with one task per scenario.
module tb_mips_mem_if;

  logic        clk = 1'b0;
  logic        reset;
  logic        cpu_rd, cpu_wr;
  logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
  logic        cpu_stall, cpu_err;
  logic        mem_req, mem_we;
  logic [29:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  int pass_cnt = 0;
  int total    = 0;
  int lowcnt   = 0;

  typedef struct {
    logic        we;
    logic [29:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
  } txn_t;

  txn_t        exp_q[$];
  logic [31:0] exp_rdata = 32'h0;

  mips_mem_if #(.AW(32), .DW(32), .TIMEOUT(8)) dut (
    .clk(clk), .reset(reset),
    .cpu_rd(cpu_rd), .cpu_wr(cpu_wr), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall), .cpu_err(cpu_err),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // One access: request cycle, lat REQ cycles (ack in the last), one DONE cycle.
  // Returns in the IDLE cycle following DONE, 1 ns after the clock edge.
  task automatic do_access(input logic rd, input logic wr, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [31:0] rdv, input int lat);
    txn_t t, got;
    t.we    = wr;
    t.addr  = addr[31:2];
    t.wdata = wdata;
    t.rdata = wr ? exp_rdata : rdv;
    exp_q.push_back(t);
    cpu_rd = rd; cpu_wr = wr; cpu_addr = addr; cpu_wdata = wdata;
    #1;
    total++;
    if (cpu_stall !== 1'b1 || mem_req !== 1'b0)
      $display("FAIL req_cycle: stall=%b req=%b, required stall=1 req=0", cpu_stall, mem_req);
    else pass_cnt++;
    @(posedge clk); #1;
    got = exp_q.pop_front();
    for (int i = 1; i <= lat; i++) begin
      total++;
      if ({mem_req, cpu_stall, mem_we, mem_addr, mem_wdata} !== {2'b11, got.we, got.addr, got.wdata})
        $display("FAIL req_hold[%0d]: req=%b stall=%b we=%b addr=%h wdata=%h, required 1 1 %b %h %h",
                 i, mem_req, cpu_stall, mem_we, mem_addr, mem_wdata, got.we, got.addr, got.wdata);
      else pass_cnt++;
      if (i == lat) begin mem_ack = 1'b1; mem_rdata = rdv; end
      @(posedge clk); #1;
      mem_ack = 1'b0; mem_rdata = $urandom;
    end
    total++;
    if ({mem_req, cpu_stall, cpu_err} !== 3'b000 || cpu_rdata !== got.rdata)
      $display("FAIL done: req=%b stall=%b err=%b rdata=%h, required 0 0 0 rdata=%h",
               mem_req, cpu_stall, cpu_err, cpu_rdata, got.rdata);
    else pass_cnt++;
    if (cpu_stall === 1'b0) lowcnt++;
    exp_rdata = got.rdata;
    @(posedge clk); #1;
    cpu_rd = 1'b0; cpu_wr = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0; cpu_rd = 0; cpu_wr = 0; cpu_addr = 0; cpu_wdata = 0;
    mem_ack = 0; mem_rdata = 0;
    repeat (2) @(posedge clk);
    #1;
    total++;
    if ({mem_req, mem_we, mem_addr, mem_wdata, cpu_rdata, cpu_err, cpu_stall} !== '0)
      $display("FAIL reset_state: req=%b we=%b addr=%h wdata=%h rdata=%h err=%b stall=%b, required all 0",
               mem_req, mem_we, mem_addr, mem_wdata, cpu_rdata, cpu_err, cpu_stall);
    else pass_cnt++;
    reset = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_read_ack1();
    do_access(1'b1, 1'b0, 32'h0000_0010, 32'h0, 32'h2008_0005, 1);
  endtask

  task automatic test_write_delay4();
    do_access(1'b0, 1'b1, 32'h0000_0054, 32'h0000_0007, 32'h1234_5678, 4);
  endtask

  task automatic test_rd_wr_both();
    do_access(1'b1, 1'b1, 32'h0000_0003, 32'hA5A5_0001, 32'h0BAD_0BAD, 2);
  endtask

  task automatic test_reset_mid_req();
    cpu_rd = 1'b1; cpu_addr = 32'h0000_0100;
    @(posedge clk); #1;
    total++;
    if (mem_req !== 1'b1) $display("FAIL rst_pre_req: req=%b, required 1", mem_req);
    else pass_cnt++;
    reset = 1'b0;
    #1;
    total++;
    if ({mem_req, mem_addr, cpu_rdata} !== '0)
      $display("FAIL rst_async: req=%b addr=%h rdata=%h, required all 0", mem_req, mem_addr, cpu_rdata);
    else pass_cnt++;
    cpu_rd = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    exp_rdata = 32'h0;
    mem_ack = 1'b1; mem_rdata = 32'hFFFF_FFFF;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      total++;
      if ({mem_req, cpu_stall} !== 2'b00 || cpu_rdata !== 32'h0)
        $display("FAIL stray_ack[%0d]: req=%b stall=%b rdata=%h, required 0 0 00000000",
                 i, mem_req, cpu_stall, cpu_rdata);
      else pass_cnt++;
    end
    mem_ack = 1'b0;
  endtask

  task automatic test_timeout();
    int reqcnt = 0;
    cpu_rd = 1'b1; cpu_addr = 32'h0000_0200;
    @(posedge clk); #1;
`ifdef MEM_TIMEOUT_EN
    while (mem_req === 1'b1 && reqcnt < 50) begin
      reqcnt++;
      @(posedge clk); #1;
    end
    total++;
    if (reqcnt != 8) $display("FAIL tmo_req_cycles: %0d, required 8", reqcnt);
    else pass_cnt++;
    total++;
    if ({cpu_err, cpu_stall} !== 2'b10 || cpu_rdata !== 32'hDEADBEEF)
      $display("FAIL tmo_done: err=%b stall=%b rdata=%h, required 1 0 deadbeef", cpu_err, cpu_stall, cpu_rdata);
    else pass_cnt++;
    cpu_rd = 1'b0;
    @(posedge clk); #1;
    total++;
    if (cpu_err !== 1'b0) $display("FAIL tmo_err_pulse: err=%b, required 0", cpu_err);
    else pass_cnt++;
    exp_rdata = 32'hDEADBEEF;
`else
    for (int i = 0; i < 40; i++) begin
      if (mem_req === 1'b1 && cpu_stall === 1'b1 && cpu_err === 1'b0) reqcnt++;
      @(posedge clk); #1;
    end
    total++;
    if (reqcnt != 40) $display("FAIL no_tmo_wait: held %0d cycles, required 40", reqcnt);
    else pass_cnt++;
    cpu_rd = 1'b0;
    reset = 1'b0; #1;
    reset = 1'b1;
    exp_rdata = 32'h0;
    @(posedge clk); #1;
`endif
  endtask

  task automatic test_back_to_back();
    lowcnt = 0;
    do_access(1'b1, 1'b0, 32'h0000_0400, 32'h0, 32'h8C08_0004, 3);
    do_access(1'b1, 1'b0, 32'h0000_1008, 32'h0, 32'hCAFE_F00D, 2);
    total++;
    if (lowcnt != 2) $display("FAIL b2b_stall_low: %0d DONE-low cycles, required 2", lowcnt);
    else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_read_ack1();
    test_write_delay4();
    test_rd_wr_both();
    test_reset_mid_req();
    test_timeout();
    test_back_to_back();
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
`default_nettype wire
